// File: rtl/vpg_pkg.sv
// Shared types and helpers for the video pattern generator: pattern modes,
// the colour-bar flag table and the frame-total calculation.
package vpg_pkg;

  typedef enum logic [1:0] {
    VPG_COLORBAR = 2'd0,
    VPG_RAMP     = 2'd1,
    VPG_GRID     = 2'd2,
    VPG_SOLID    = 2'd3
  } vpg_mode_e;

  // Bar colours as {R,G,B} on/off flags, SMPTE-style order left to right.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    logic [2:0] f;
    case (idx)
      3'd0:    f = 3'b111;
      3'd1:    f = 3'b110;
      3'd2:    f = 3'b011;
      3'd3:    f = 3'b010;
      3'd4:    f = 3'b101;
      3'd5:    f = 3'b100;
      3'd6:    f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  function automatic int calc_total(input int sync_w, input int bp_w,
                                    input int active_w, input int fp_w);
    return sync_w + bp_w + active_w + fp_w;
  endfunction

endpackage

// File: rtl/vpg_timing.sv
// Raster timing: h/v counters, sync/de decode and active x/y, registered once.
// Counter-domain strobes are exported so a consumer can align its own logic.
module vpg_timing
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        frame_tick,
  output logic        act_first,
  output logic        act_en,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        frame_start
);

  localparam int H_TOTAL = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;

  if (H_ACTIVE > 2047 || V_ACTIVE > 2047) begin : g_bad_active
    $error("vpg_timing: active area exceeds the 11-bit position range");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_act;
  logic          v_act;

  assign h_wrap     = (int'(h_cnt) == H_TOTAL - 1);
  assign v_wrap     = (int'(v_cnt) == V_TOTAL - 1);
  assign h_act      = (int'(h_cnt) >= H_START) && (int'(h_cnt) < H_END);
  assign v_act      = (int'(v_cnt) >= V_START) && (int'(v_cnt) < V_END);
  assign act_en     = h_act && v_act;
  assign act_first  = act_en && (int'(h_cnt) == H_START);
  assign frame_tick = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // v_cnt only moves on the h wrap, so vs naturally changes at h_cnt==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= (int'(h_cnt) < H_SYNC) ? HS_POL : ~HS_POL;
      vs          <= (int'(v_cnt) < V_SYNC) ? VS_POL : ~VS_POL;
      de          <= act_en;
      xpos        <= act_en ? 11'(h_cnt) - 11'(H_START) : '0;
      ypos        <= act_en ? 11'(v_cnt) - 11'(V_START) : '0;
      frame_start <= frame_tick;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing plus run-time selectable test pattern, mode latched per frame.
// Define VPG_SCROLL_EN to scroll colorbar/ramp left one pixel per frame.
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int PIX_W      = 8,
  parameter int NUM_BARS   = 8,
  parameter int GRID_SHIFT = 4
) (
  input  logic               pixel_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic [3*PIX_W-1:0] solid_rgb,
  output logic               video_hs,
  output logic               video_vs,
  output logic               video_de,
  output logic [3*PIX_W-1:0] video_rgb,
  output logic [10:0]        pixel_xpos,
  output logic [10:0]        pixel_ypos,
  output logic               frame_start
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int PW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int IW    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  if (H_ACTIVE % NUM_BARS != 0) begin : g_bad_bars
    $error("video_pattern_gen: H_ACTIVE must be a multiple of NUM_BARS");
  end

  logic        frame_tick;
  logic        act_first;
  logic        act_en;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_de;
  logic [10:0] s1_x;
  logic [10:0] s1_y;
  logic        s1_fs;

  vpg_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk        (pixel_clk),
    .rst_n      (sys_rst_n),
    .frame_tick (frame_tick),
    .act_first  (act_first),
    .act_en     (act_en),
    .hs         (s1_hs),
    .vs         (s1_vs),
    .de         (s1_de),
    .xpos       (s1_x),
    .ypos       (s1_y),
    .frame_start(s1_fs)
  );

  vpg_mode_e         mode_q;
  logic [PW-1:0]     bar_pix;
  logic [IW-1:0]     bar_idx;
  logic [PW-1:0]     start_pix;
  logic [IW-1:0]     start_idx;
  logic [10:0]       eff_x;
  logic [2:0]        bar_on;
  logic              grid_on;
  logic [3*PIX_W-1:0] pat;

  // Sampled on the frame's first counter cycle, so a whole frame uses one mode.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) mode_q <= VPG_COLORBAR;
    else if (frame_tick) mode_q <= vpg_mode_e'(mode);
  end

`ifdef VPG_SCROLL_EN
  logic [10:0]   frame_cnt;
  logic [PW-1:0] pre_pix;
  logic [IW-1:0] pre_idx;
  logic [11:0]   x_sum;

  // pre_pix/pre_idx track frame_cnt as a bar position, avoiding a divider.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      pre_pix   <= '0;
      pre_idx   <= '0;
    end else if (frame_tick) begin
      frame_cnt <= (int'(frame_cnt) == H_ACTIVE - 1) ? '0 : frame_cnt + 1'b1;
      if (int'(pre_pix) == BAR_W - 1) begin
        pre_pix <= '0;
        pre_idx <= (int'(pre_idx) == NUM_BARS - 1) ? '0 : pre_idx + 1'b1;
      end else begin
        pre_pix <= pre_pix + 1'b1;
      end
    end
  end

  assign x_sum     = {1'b0, s1_x} + {1'b0, frame_cnt};
  assign eff_x     = (int'(x_sum) >= H_ACTIVE) ? 11'(x_sum - 12'(H_ACTIVE)) : x_sum[10:0];
  assign start_pix = pre_pix;
  assign start_idx = pre_idx;
`else
  assign eff_x     = s1_x;
  assign start_pix = '0;
  assign start_idx = '0;
`endif

  // Bar position of the pixel currently held in stage 1.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (act_first) begin
      bar_pix <= start_pix;
      bar_idx <= start_idx;
    end else if (act_en) begin
      if (int'(bar_pix) == BAR_W - 1) begin
        bar_pix <= '0;
        bar_idx <= (int'(bar_idx) == NUM_BARS - 1) ? '0 : bar_idx + 1'b1;
      end else begin
        bar_pix <= bar_pix + 1'b1;
      end
    end
  end

  assign bar_on  = bar_flags(3'(bar_idx));
  assign grid_on = (s1_x[GRID_SHIFT-1:0] == '0) || (s1_y[GRID_SHIFT-1:0] == '0) ||
                   (int'(s1_x) == H_ACTIVE - 1) || (int'(s1_y) == V_ACTIVE - 1);

  always_comb begin
    pat = '0;
    unique case (mode_q)
      VPG_COLORBAR: pat = {{PIX_W{bar_on[2]}}, {PIX_W{bar_on[1]}}, {PIX_W{bar_on[0]}}};
      VPG_RAMP:     pat = {3{PIX_W'(eff_x)}};
      VPG_GRID:     pat = grid_on ? '1 : '0;
      VPG_SOLID:    pat = solid_rgb;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      video_hs    <= ~HS_POL;
      video_vs    <= ~VS_POL;
      video_de    <= 1'b0;
      video_rgb   <= '0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= s1_hs;
      video_vs    <= s1_vs;
      video_de    <= s1_de;
      video_rgb   <= s1_de ? pat : '0;
      pixel_xpos  <= s1_x;
      pixel_ypos  <= s1_y;
      frame_start <= s1_fs;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: small raster checked every cycle against an
// arithmetic raster model, plus a 1280-wide instance for ramp wrap points.
module tb_video_pattern_gen;

  localparam int HA = 16, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HSY + HBP + HA + HFP;   // 22
  localparam int VT = VSY + VBP + VA + VFP;   // 7
  localparam int FT = HT * VT;                // 154
  localparam int WHA = 1280;
  localparam int WFT = (WHA + 6) * 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic        video_hs, video_vs, video_de, frame_start;
  logic [23:0] video_rgb;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        w_hs, w_vs, w_de, w_fs;
  logic [23:0] w_rgb;
  logic [10:0] w_x, w_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wide_hits = 0;
  logic [1:0] frame_mode [0:63];

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIX_W(8), .NUM_BARS(8), .GRID_SHIFT(2)
  ) dut (
    .pixel_clk(clk), .sys_rst_n(rst_n), .mode(mode), .solid_rgb(solid),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start)
  );

  video_pattern_gen #(
    .H_ACTIVE(WHA), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_W(8), .NUM_BARS(8), .GRID_SHIFT(4)
  ) dut_wide (
    .pixel_clk(clk), .sys_rst_n(rst_n), .mode(2'd1), .solid_rgb(24'h0),
    .video_hs(w_hs), .video_vs(w_vs), .video_de(w_de),
    .video_rgb(w_rgb), .pixel_xpos(w_x), .pixel_ypos(w_y),
    .frame_start(w_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int scroll_off(input int frame, input int width);
    int off;
    off = 0;
`ifdef VPG_SCROLL_EN
    off = (frame + 1) % width;
`endif
    return off;
  endfunction

  function automatic logic [23:0] model_rgb(input logic [1:0] md, input int x, input int y,
                                            input int frame, input logic [23:0] sol);
    int ex;
    ex = (x + scroll_off(frame, HA)) % HA;
    case (md)
      2'd0: return bar_colour((ex / (HA / 8)) % 8);
      2'd1: return {3{8'(ex % 256)}};
      2'd2: return (x % 4 == 0 || y % 4 == 0 || x == HA - 1 || y == VA - 1) ? 24'hFFFFFF : 24'h0;
      default: return sol;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hs"}, video_hs, 1);
    chk({tag, "_vs"}, video_vs, 0);
    chk({tag, "_de"}, video_de, 0);
    chk({tag, "_rgb"}, video_rgb, 0);
    chk({tag, "_x"}, pixel_xpos, 0);
    chk({tag, "_y"}, pixel_ypos, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  // One clock; then compare every output with the raster model.
  task automatic step();
    int k, h, v, f, x, y, wf, wex;
    logic de_e;
    @(posedge clk);
    cyc++;
    if ((cyc - 1) % FT == 0) frame_mode[((cyc - 1) / FT) % 64] = mode;
    @(negedge clk);
    if (cyc < 2) begin
      chk_reset_outputs("pre_pipe");
    end else begin
      k = cyc - 2;
      h = k % HT;
      v = (k / HT) % VT;
      f = k / FT;
      de_e = (h >= HSY + HBP) && (h < HSY + HBP + HA) && (v >= VSY + VBP) && (v < VSY + VBP + VA);
      x = de_e ? h - (HSY + HBP) : 0;
      y = de_e ? v - (VSY + VBP) : 0;
      chk("hs", video_hs, (h < HSY) ? 0 : 1);
      chk("vs", video_vs, (v < VSY) ? 1 : 0);
      chk("de", video_de, de_e);
      chk("xpos", pixel_xpos, x);
      chk("ypos", pixel_ypos, y);
      chk("frame_start", frame_start, (k % FT) == 0);
      chk("rgb", video_rgb, de_e ? model_rgb(frame_mode[f % 64], x, y, f, solid) : 24'h0);
    end
    if (w_de && (w_x == 11'd255 || w_x == 11'd256 || w_x == 11'd300)) begin
      wide_hits++;
      wf = (cyc - 2) / WFT;
      wex = (int'(w_x) + scroll_off(wf, WHA)) % WHA;
      chk("ramp_wide", w_rgb, {3{8'(wex % 256)}});
    end
  endtask

  initial begin
    bit found;
    mode  = 2'd0;
    solid = 24'h123456;
    #1 rst_n = 1'b0;
    #11;
    chk_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (2 * FT) step();

    // Mid-frame switch to solid: current frame must finish as colorbar.
    repeat (60) step();
    mode = 2'd3;
    repeat (2 * FT) step();

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(10, 150)) step();
      mode  = 2'($urandom_range(0, 3));
      solid = 24'($urandom);
    end

    // Long colorbar run covers a full scroll period when scrolling is built in.
    mode = 2'd0;
    repeat (17 * FT) step();

    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      if ((cyc % HT) == 10 && ((cyc / HT) % VT) >= 2 && ((cyc / HT) % VT) < 6) found = 1'b1;
      else step();
    end
    chk("find_midline", found, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    cyc = 0;
    mode = 2'd2;
    step();
    chk("fs_edge1", frame_start, 0);
    step();
    chk("fs_edge2", frame_start, 1);
    repeat (2 * FT) step();
    mode = 2'd1;
    repeat (2 * FT) step();
    chk("wide_ramp_seen", wide_hits >= 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
